multi_counter: RTL and testbench

Parametrised multi-channel up/down counter, the next-generation replacement for the single-channel counter DUT used by the counter testbench (tester, checker, monitor). It provides NCH independent channels of WIDTH bits with a programmable terminal value, per-channel direction, clear and load, terminal-count flags, and sticky overflow flags. It is driven through an extended counter interface and verified by the same package-based class bench.

---
 rtl/multi_counter_pkg.sv | 21 ++
 rtl/multi_counter_if.sv | 31 +++
 rtl/multi_counter_ch.sv | 73 +++++++
 rtl/multi_counter.sv | 55 +++++
 tb/tb_multi_counter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/multi_counter_pkg.sv
// Shared constants, load-channel width helper and per-channel operation priority
// for the multi-channel counter and its reference model.
package counter_pkg;

  localparam int MC_NCH   = 4;
  localparam int MC_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_CLR,
    OP_LD,
    OP_UP,
    OP_DN,
    OP_HOLD
  } op_t;

  function automatic int chw(input int n);
    if (n <= 1) return 1;
    else        return $clog2(n);
  endfunction

endpackage

// File: rtl/multi_counter_if.sv
// Control/status bundle for multi_counter. The sat vector only exists when
// MULTI_COUNTER_SAT_EN is defined.
interface multi_counter_if
  import counter_pkg::*;
#(
  parameter int NCH   = MC_NCH,
  parameter int WIDTH = MC_WIDTH
);

  logic [NCH-1:0]       en;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       clr;
  logic                 ld;
  logic [chw(NCH)-1:0]  ld_ch;
  logic [WIDTH-1:0]     ld_val;
`ifdef MULTI_COUNTER_SAT_EN
  logic [NCH-1:0]       sat;
`endif
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       tc;
  logic [NCH-1:0]       ovf;

`ifdef MULTI_COUNTER_SAT_EN
  modport master (output en, dir, clr, ld, ld_ch, ld_val, sat, input count, tc, ovf);
  modport slave  (input en, dir, clr, ld, ld_ch, ld_val, sat, output count, tc, ovf);
`else
  modport master (output en, dir, clr, ld, ld_ch, ld_val, input count, tc, ovf);
  modport slave  (input en, dir, clr, ld, ld_ch, ld_val, output count, tc, ovf);
`endif

endinterface

// File: rtl/multi_counter_ch.sv
// One counter channel: clear > load > up > down > hold, modulo MAXV+1,
// with sticky overflow and combinational terminal count.
module multi_counter_ch
  import counter_pkg::*;
#(
  parameter int WIDTH = MC_WIDTH,
  parameter int MAXV  = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             ld,
  input  logic             sat,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAXW = WIDTH'(MAXV);

  op_t  op;
  logic at_max;
  logic at_zero;

  assign at_max  = (count == MAXW);
  assign at_zero = (count == '0);
  assign tc      = dir ? at_max : at_zero;

  always_comb begin
    op = OP_HOLD;
    if (clr)             op = OP_CLR;
    else if (ld)         op = OP_LD;
    else if (en && dir)  op = OP_UP;
    else if (en)         op = OP_DN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          count <= '0;
          ovf   <= 1'b0;
        end
        // loads are clipped so the count never leaves 0..MAXV
        OP_LD: count <= (ld_val > MAXW) ? MAXW : ld_val;
        OP_UP: begin
          if (at_max) begin
            ovf <= 1'b1;
            if (!sat) count <= '0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end
        OP_DN: begin
          if (at_zero) begin
            ovf <= 1'b1;
            if (!sat) count <= MAXW;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_counter.sv
// NCH-channel up/down counter top: decodes the single load port into per-channel
// strobes. Saturate mode is built in when MULTI_COUNTER_SAT_EN is defined.
module multi_counter
  import counter_pkg::*;
#(
  parameter int NCH   = MC_NCH,
  parameter int WIDTH = MC_WIDTH,
  parameter int MAXV  = (1 << WIDTH) - 1
) (
  input  logic            clk,
  input  logic            rst,
  multi_counter_if.slave  bus
);

  localparam int CHW = chw(NCH);

  logic [NCH-1:0]       ld_hit;
  logic [NCH-1:0]       sat_w;
  logic [NCH*WIDTH-1:0] count_w;
  logic [NCH-1:0]       tc_w;
  logic [NCH-1:0]       ovf_w;

`ifdef MULTI_COUNTER_SAT_EN
  assign sat_w = bus.sat;
`else
  assign sat_w = '0;
`endif

  assign bus.count = count_w;
  assign bus.tc    = tc_w;
  assign bus.ovf   = ovf_w;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // an out-of-range ld_ch matches no channel and is dropped
    assign ld_hit[i] = bus.ld && (bus.ld_ch == CHW'(i));

    multi_counter_ch #(
      .WIDTH (WIDTH),
      .MAXV  (MAXV)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.en[i]),
      .dir    (bus.dir[i]),
      .clr    (bus.clr[i]),
      .ld     (ld_hit[i]),
      .sat    (sat_w[i]),
      .ld_val (bus.ld_val),
      .count  (count_w[i*WIDTH +: WIDTH]),
      .ovf    (ovf_w[i]),
      .tc     (tc_w[i])
    );
  end

endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: dut_a is 5x8 bit full-range, dut_b is 4x8 bit
// with MAXV=9. Saturate vectors run only with MULTI_COUNTER_SAT_EN.
module tb_multi_counter;
  import counter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_counter_if #(.NCH(5), .WIDTH(8)) ifa ();
  multi_counter_if #(.NCH(4), .WIDTH(8)) ifb ();

  multi_counter #(.NCH(5), .WIDTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  multi_counter #(.NCH(4), .WIDTH(8), .MAXV(9)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_cnt [4];
  logic       m_ovf [4];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cnt_b(input int i);
    return ifb.count[i*8 +: 8];
  endfunction

  initial begin
    op_t op;
    rst        = 1'b1;
    ifa.en     = '0; ifa.dir = '0; ifa.clr = '0;
    ifa.ld     = 1'b0; ifa.ld_ch = '0; ifa.ld_val = '0;
    ifb.en     = '0; ifb.dir = '0; ifb.clr = '0;
    ifb.ld     = 1'b0; ifb.ld_ch = '0; ifb.ld_val = '0;
`ifdef MULTI_COUNTER_SAT_EN
    ifa.sat    = '0;
    ifb.sat    = '0;
`endif
    repeat (2) tick();

    chk("rst_count_b", ifb.count, 32'h0);
    chk("rst_ovf_b",   ifb.ovf, 4'h0);
    chk("rst_tc_b",    ifb.tc, 4'hF);
    chk("rst_count_a", ifa.count, 40'h0);
    rst = 1'b0;

    // reset mid-count on dut_a channel 0
    ifa.dir[0] = 1'b1;
    ifa.en[0]  = 1'b1;
    tick();
    chk("rel_tc_a0", ifa.tc[0], 1'b1 ^ 1'b1);
    repeat (36) tick();
    chk("cnt37_a0", ifa.count[7:0], 8'd37);
    #3 rst = 1'b1;
    #1;
    chk("async_cnt_a0", ifa.count[7:0], 8'd0);
    chk("async_ovf_a",  ifa.ovf, 5'h0);
    chk("async_tc_a0",  ifa.tc[0], 1'b0);
    ifa.en = '0;
    tick();
    rst = 1'b0;

    // up-count wrap on channel 1, MAXV=9
    ifb.dir[1] = 1'b1;
    ifb.en[1]  = 1'b1;
    chk("up_start", cnt_b(1), 8'd0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("up_cnt_%0d", k), cnt_b(1), 8'(k % 10));
      chk($sformatf("up_tc_%0d", k),  ifb.tc[1], 1'((k % 10) == 9));
      chk($sformatf("up_ovf_%0d", k), ifb.ovf[1], 1'(k >= 10));
    end
    ifb.en[1] = 1'b0;

    // down-count wrap on channel 2
    ifb.ld = 1'b1; ifb.ld_ch = 2'd2; ifb.ld_val = 8'd1;
    tick();
    ifb.ld = 1'b0;
    chk("dn_load", cnt_b(2), 8'd1);
    ifb.en[2] = 1'b1;
    tick(); chk("dn_c1", cnt_b(2), 8'd0); chk("dn_o1", ifb.ovf[2], 1'b0);
    chk("dn_tc1", ifb.tc[2], 1'b1);
    tick(); chk("dn_c2", cnt_b(2), 8'd9); chk("dn_o2", ifb.ovf[2], 1'b1);
    tick(); chk("dn_c3", cnt_b(2), 8'd8); chk("dn_o3", ifb.ovf[2], 1'b1);
    ifb.en[2]  = 1'b0;
    ifb.clr[2] = 1'b1;
    tick();
    ifb.clr[2] = 1'b0;
    chk("dn_clr_c", cnt_b(2), 8'd0);
    chk("dn_clr_o", ifb.ovf[2], 1'b0);

    // load priority and clipping
    ifb.ld = 1'b1; ifb.ld_ch = 2'd0; ifb.ld_val = 8'd200;
    tick();
    chk("ld_clip", cnt_b(0), 8'd9);
    ifb.ld_ch = 2'd1; ifb.ld_val = 8'd4;
    tick();
    chk("ld_c1", cnt_b(1), 8'd4);
    chk("ld_keeps_ovf", ifb.ovf[1], 1'b1);
    ifb.ld_ch = 2'd3; ifb.ld_val = 8'd5;
    tick();
    chk("ld_c3", cnt_b(3), 8'd5);
    chk("ld_c0_hold", cnt_b(0), 8'd9);
    ifb.clr[3] = 1'b1;
    tick();
    ifb.clr[3] = 1'b0;
    ifb.ld = 1'b0;
    chk("clr_over_ld", cnt_b(3), 8'd0);

    ifa.ld = 1'b1; ifa.ld_ch = 3'd5; ifa.ld_val = 8'd77;
    tick();
    chk("ld_oor", ifa.count, 40'h0);
    ifa.ld_ch = 3'd4;
    tick();
    ifa.ld = 1'b0;
    chk("ld_last", ifa.count, {8'd77, 32'h0});

    // independence against reference model
    ifb.clr = 4'hF;
    tick();
    ifb.clr = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 8'd0;
      m_ovf[i] = 1'b0;
    end
    ifb.dir = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      if (c == 10) ifb.dir = ifb.dir ^ 4'b0011;
      ifb.en = {c[0], 3'b111};
      ifb.ld = (c == 5);
      ifb.ld_ch = 2'd2;
      ifb.ld_val = 8'd7;
      for (int i = 0; i < 4; i++) begin
        if (ifb.clr[i])                      op = OP_CLR;
        else if (ifb.ld && ifb.ld_ch == i)   op = OP_LD;
        else if (ifb.en[i] && ifb.dir[i])    op = OP_UP;
        else if (ifb.en[i])                  op = OP_DN;
        else                                 op = OP_HOLD;
        case (op)
          OP_CLR: begin m_cnt[i] = 8'd0; m_ovf[i] = 1'b0; end
          OP_LD:  m_cnt[i] = (ifb.ld_val > 8'd9) ? 8'd9 : ifb.ld_val;
          OP_UP:  if (m_cnt[i] == 8'd9) begin m_cnt[i] = 8'd0; m_ovf[i] = 1'b1; end
                  else m_cnt[i] = m_cnt[i] + 8'd1;
          OP_DN:  if (m_cnt[i] == 8'd0) begin m_cnt[i] = 8'd9; m_ovf[i] = 1'b1; end
                  else m_cnt[i] = m_cnt[i] - 8'd1;
          default: ;
        endcase
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ind_cnt_c%0d_ch%0d", c, i), cnt_b(i), m_cnt[i]);
        chk($sformatf("ind_ovf_c%0d_ch%0d", c, i), ifb.ovf[i], m_ovf[i]);
        chk($sformatf("ind_tc_c%0d_ch%0d", c, i), ifb.tc[i],
            ifb.dir[i] ? (m_cnt[i] == 8'd9) : (m_cnt[i] == 8'd0));
      end
    end
    ifb.en = '0;
    ifb.ld = 1'b0;

`ifdef MULTI_COUNTER_SAT_EN
    ifb.clr = 4'h1;
    tick();
    ifb.clr = 4'h0;
    ifb.ld = 1'b1; ifb.ld_ch = 2'd0; ifb.ld_val = 8'd8;
    tick();
    ifb.ld = 1'b0;
    ifb.sat[0] = 1'b1;
    ifb.dir[0] = 1'b1;
    ifb.en[0]  = 1'b1;
    tick(); chk("sat_c1", cnt_b(0), 8'd9); chk("sat_o1", ifb.ovf[0], 1'b0);
    tick(); chk("sat_c2", cnt_b(0), 8'd9); chk("sat_o2", ifb.ovf[0], 1'b1);
    tick(); chk("sat_c3", cnt_b(0), 8'd9); chk("sat_o3", ifb.ovf[0], 1'b1);
    ifb.sat[0] = 1'b0;
    tick(); chk("sat_off_wrap", cnt_b(0), 8'd0);
    ifb.en = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
